// File: rtl/audio_in_pkg.sv
// Shared types and constants for the ADC-side hit detector.
package audio_in_pkg;

    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned DC_SHIFT = 10;

    typedef enum logic [1:0] {
        S_WAIT,
        S_READ,
        S_ACC,
        S_EVAL
    } state_t;

    // Exact log2 for a power-of-two window up to 1024 samples.
    function automatic int unsigned LOG2_WINDOW(input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 11; i++) begin
            if ((32'd1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_abs_mag.sv
// Combinational per-sample magnitude: (|L|>>1) + (|R|>>1), with an optional DC-removal stage.
// Optional feature macro: HIT_DC_BLOCK_EN (filter state registers live in the parent).
module audio_abs_mag
    import audio_in_pkg::*;
(
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
`ifdef HIT_DC_BLOCK_EN
    input  logic [SAMPLE_W-1:0] left_dc,
    input  logic [SAMPLE_W-1:0] right_dc,
    output logic [SAMPLE_W-1:0] left_dc_next,
    output logic [SAMPLE_W-1:0] right_dc_next,
`endif
    output logic [SAMPLE_W-1:0] mag
);

    // Most-negative input saturates so |x| always fits in SAMPLE_W-1 bits.
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
        if (!x[SAMPLE_W-1]) return x;
        if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) return {1'b0, {(SAMPLE_W-1){1'b1}}};
        return ~x + SAMPLE_W'(1);
    endfunction

    logic [SAMPLE_W-1:0] left_y;
    logic [SAMPLE_W-1:0] right_y;

`ifdef HIT_DC_BLOCK_EN
    function automatic logic signed [SAMPLE_W:0] dc_diff(input logic [SAMPLE_W-1:0] x,
                                                         input logic [SAMPLE_W-1:0] d);
        return $signed({x[SAMPLE_W-1], x}) - $signed({d[SAMPLE_W-1], d});
    endfunction

    function automatic logic [SAMPLE_W-1:0] sat_w(input logic signed [SAMPLE_W:0] v);
        if (v[SAMPLE_W] != v[SAMPLE_W-1])
            return v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        return v[SAMPLE_W-1:0];
    endfunction

    // d moves a 1/2^DC_SHIFT step toward x; it stays between d and x so never overflows.
    function automatic logic [SAMPLE_W-1:0] dc_step(input logic [SAMPLE_W-1:0] d,
                                                    input logic signed [SAMPLE_W:0] diff);
        logic signed [SAMPLE_W:0] sum;
        sum = $signed({d[SAMPLE_W-1], d}) + (diff >>> DC_SHIFT);
        return sum[SAMPLE_W-1:0];
    endfunction

    logic signed [SAMPLE_W:0] left_diff;
    logic signed [SAMPLE_W:0] right_diff;

    assign left_diff     = dc_diff(left, left_dc);
    assign right_diff    = dc_diff(right, right_dc);
    assign left_y        = sat_w(left_diff);
    assign right_y       = sat_w(right_diff);
    assign left_dc_next  = dc_step(left_dc, left_diff);
    assign right_dc_next = dc_step(right_dc, right_diff);
`else
    assign left_y  = left;
    assign right_y = right;
`endif

    assign mag = (sat_abs(left_y) >> 1) + (sat_abs(right_y) >> 1);

endmodule

// File: rtl/audio_hit_detector.sv
// Drains the ADC FIFO, averages sample magnitude over WINDOW samples and pulses hit on loud events.
// Optional feature macro: HIT_DC_BLOCK_EN enables per-channel DC removal ahead of the magnitude.
module audio_hit_detector
    import audio_in_pkg::*;
#(
    parameter int unsigned   WINDOW         = 64,
    parameter logic [31:0]   THRESHOLD      = 32'h0200_0000,
    parameter int unsigned   HOLDOFF_CYCLES = 12_500_000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic                audio_in_available,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    output logic                hit,
    output logic [7:0]          level,
    output logic                holdoff_active
);

    localparam int unsigned LOG2_W = LOG2_WINDOW(WINDOW);
    localparam int unsigned ACC_W  = SAMPLE_W + LOG2_W;
    localparam int unsigned CNT_W  = LOG2_W + 1;
    localparam int unsigned HOLD_W = 32;

    state_t              state;
    state_t              next_state;
    logic                read_next;
    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] right_q;
    logic [SAMPLE_W-1:0] mag;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] mean;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_next;
    logic                hit_set;

`ifdef HIT_DC_BLOCK_EN
    logic [SAMPLE_W-1:0] left_dc;
    logic [SAMPLE_W-1:0] right_dc;
    logic [SAMPLE_W-1:0] left_dc_next;
    logic [SAMPLE_W-1:0] right_dc_next;
`endif

    audio_abs_mag u_mag (
        .left          (left_q),
        .right         (right_q),
`ifdef HIT_DC_BLOCK_EN
        .left_dc       (left_dc),
        .right_dc      (right_dc),
        .left_dc_next  (left_dc_next),
        .right_dc_next (right_dc_next),
`endif
        .mag           (mag)
    );

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= S_WAIT;
        else       state <= next_state;
    end

    // Next-state; the pop strobe is registered from the state being entered
    always_comb begin
        next_state = state;
        read_next  = 1'b0;
        case (state)
            S_WAIT:  if (audio_in_available) next_state = S_READ;
            S_READ:  next_state = S_ACC;
            S_ACC:   next_state = (enable && cnt == CNT_W'(WINDOW - 1)) ? S_EVAL : S_WAIT;
            S_EVAL:  next_state = S_WAIT;
            default: next_state = S_WAIT;
        endcase
        read_next = (next_state == S_READ);
    end

    // Window evaluation and holdoff timer
    always_comb begin
        mean    = SAMPLE_W'(acc >> LOG2_W);
        hit_set = (state == S_EVAL) && enable && (mean > THRESHOLD) && (hold == '0);
        if (hit_set)          hold_next = HOLD_W'(HOLDOFF_CYCLES);
        else if (hold != '0)  hold_next = hold - HOLD_W'(1);
        else                  hold_next = hold;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            read_audio_in  <= 1'b0;
            hit            <= 1'b0;
            level          <= '0;
            holdoff_active <= 1'b0;
            left_q         <= '0;
            right_q        <= '0;
            acc            <= '0;
            cnt            <= '0;
            hold           <= '0;
        end else begin
            read_audio_in  <= read_next;
            hit            <= hit_set;
            hold           <= hold_next;
            holdoff_active <= (hold_next != '0);
            if (state == S_READ) begin
                left_q  <= left_channel_audio_in;
                right_q <= right_channel_audio_in;
            end
            // Disabled: keep draining but never build a window
            if (!enable) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == S_ACC) begin
                acc <= acc + ACC_W'(mag);
                cnt <= cnt + CNT_W'(1);
            end else if (state == S_EVAL) begin
                acc   <= '0;
                cnt   <= '0;
                level <= mean[31:24];
            end
        end
    end

`ifdef HIT_DC_BLOCK_EN
    // DC estimate follows every drained sample; cleared only by reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            left_dc  <= '0;
            right_dc <= '0;
        end else if (state == S_ACC) begin
            left_dc  <= left_dc_next;
            right_dc <= right_dc_next;
        end
    end
`endif

endmodule

// File: tb/tb_audio_hit_detector.sv
// Directed self-checking bench for audio_hit_detector (WINDOW=4, THRESHOLD=0x0100_0000, HOLDOFF=100).
module tb_audio_hit_detector;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        available;
    logic [31:0] left;
    logic [31:0] right;
    logic        read;
    logic        hit;
    logic [7:0]  level;
    logic        holdoff_active;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gap_bad  = 0;
    int consec   = 0;
    int pop_total  = 0;
    int hits_total = 0;
    int late_hits  = 0;
    int eval_cyc   = 0;
    logic prev_read = 1'b0;

    audio_hit_detector #(
        .WINDOW         (4),
        .THRESHOLD      (32'h0100_0000),
        .HOLDOFF_CYCLES (100)
    ) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .enable                 (enable),
        .audio_in_available     (available),
        .left_channel_audio_in  (left),
        .right_channel_audio_in (right),
        .read_audio_in          (read),
        .hit                    (hit),
        .level                  (level),
        .holdoff_active         (holdoff_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (read && prev_read) consec <= consec + 1;
        prev_read <= read;
        if (read) pop_total <= pop_total + 1;
        if (hit) hits_total <= hits_total + 1;
        if (hit && pop_total > 4096) late_hits <= late_hits + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a constant sample for n pops; withdraw availability at the n-th pop.
    task automatic run_window(input logic [31:0] l, input logic [31:0] r, input int n);
        int last;
        int budget;
        last = 0;
        left = l;
        right = r;
        available = 1'b1;
        for (int i = 0; i < n; i++) begin
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!read && budget < 50);
            if (!read) begin
                check("pop_timeout", 32'(read), 32'd1);
                available = 1'b0;
                return;
            end
            if (i > 0 && (cyc - last) != 3) gap_bad++;
            last = cyc;
        end
        available = 1'b0;
    endtask

    // Called at the negedge of the last pop (cycle t): hit/level land at t+3 for one cycle.
    task automatic check_eval(input string tag, input logic exp_hit, input logic [7:0] exp_level);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_hit_early"}, 32'(hit), 32'd0);
        @(negedge clk);
        eval_cyc = cyc;
        check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        check({tag, "_level"}, 32'(level), 32'(exp_level));
        @(negedge clk);
        check({tag, "_hit_pulse"}, 32'(hit), 32'd0);
    endtask

    task automatic wait_holdoff_clear();
        int budget;
        budget = 0;
        while (holdoff_active && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (holdoff_active) check("holdoff_timeout", 32'(holdoff_active), 32'd0);
    endtask

    initial begin
        int hc;
        int budget;
        reset = 1'b1;
        enable = 1'b0;
        available = 1'b0;
        left = '0;
        right = '0;
        repeat (3) @(negedge clk);
        check("rst_read", 32'(read), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_holdoff", 32'(holdoff_active), 32'd0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);

`ifdef HIT_DC_BLOCK_EN
        // Constant input is removed by the DC filter; level decays to zero
        left = 32'h0400_0000;
        right = 32'h0400_0000;
        available = 1'b1;
        budget = 0;
        while (pop_total < 8192 && budget < 40000) begin
            @(negedge clk);
            budget++;
        end
        available = 1'b0;
        check("dc_pops", 32'(pop_total >= 8192), 32'd1);
        repeat (6) @(negedge clk);
        check("dc_level", 32'(level), 32'd0);
        check("dc_early_hit", 32'(hits_total > 0), 32'd1);
        check("dc_late_hits", 32'(late_hits), 32'd0);
`else
        // 1: loud positive window
        run_window(32'h0400_0000, 32'h0400_0000, 4);
        check_eval("t1", 1'b1, 8'h04);
        check("t1_holdoff", 32'(holdoff_active), 32'd1);
        wait_holdoff_clear();

        // 2: sign removed; most-negative saturates
        run_window(32'hFC00_0000, 32'hFC00_0000, 4);
        check_eval("t2_neg", 1'b1, 8'h04);
        wait_holdoff_clear();
        run_window(32'h8000_0000, 32'h8000_0000, 4);
        check_eval("t2_min", 1'b1, 8'h7F);
        wait_holdoff_clear();

        // 3: mean equal to threshold is not a hit
        run_window(32'h0100_0000, 32'h0100_0000, 4);
        check_eval("t3_eq", 1'b0, 8'h01);
        check("t3_holdoff", 32'(holdoff_active), 32'd0);

        // 4: holdoff masks the second loud window and runs exactly 100 cycles
        run_window(32'h0400_0000, 32'h0400_0000, 4);
        check_eval("t4a", 1'b1, 8'h04);
        hc = eval_cyc;
        run_window(32'h0800_0000, 32'h0800_0000, 4);
        check_eval("t4b", 1'b0, 8'h08);
        budget = 0;
        while (cyc < hc + 99 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("t4_holdoff_last", 32'(holdoff_active), 32'd1);
        @(negedge clk);
        check("t4_holdoff_end", 32'(holdoff_active), 32'd0);
        run_window(32'h0400_0000, 32'h0400_0000, 4);
        check_eval("t4c", 1'b1, 8'h04);

        // 5: disabled drain, then reset mid-window
        enable = 1'b0;
        run_window(32'h0800_0000, 32'h0800_0000, 6);
        repeat (4) begin
            @(negedge clk);
            check("t5_dis_hit", 32'(hit), 32'd0);
        end
        check("t5_dis_level", 32'(level), 32'h04);
        enable = 1'b1;
        run_window(32'h0800_0000, 32'h0800_0000, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_read", 32'(read), 32'd0);
        check("t5_rst_hit", 32'(hit), 32'd0);
        check("t5_rst_level", 32'(level), 32'd0);
        check("t5_rst_holdoff", 32'(holdoff_active), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_window(32'h0800_0000, 32'h0800_0000, 4);
        check_eval("t5_fresh", 1'b1, 8'h08);
        check("pop_spacing", 32'(gap_bad), 32'd0);
`endif
        check("no_back_to_back_pops", 32'(consec), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
